monus_func_h: RTL and testbench

- Truncated-subtraction (monus) function block, the inverse of the iterated-successor addition block: RES = IN0 ∸ IN1, i.e. max(IN0 − IN1, 0).
- Built as a primitive-recursion iteration of the predecessor operation: the accumulator is decremented once per clock, IN1 times.
- Uses the same ST/RD start-ready chaining as the other function blocks, so its RD can drive a downstream ST directly.

---
 rtl/monus_func_h_pkg.sv | 13 +
 rtl/monus_func_h_p_step.sv | 15 +
 rtl/monus_func_h.sv | 106 ++++++++++
 tb/tb_monus_func_h.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/monus_func_h_pkg.sv
// Shared constants and state encoding for the predecessor-based function blocks.
package monus_func_h_pkg;

   localparam int BW_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/monus_func_h_p_step.sv
// Combinational saturating predecessor: y = x-1, clamped at 0, with a zero flag on y.
module operation_p_step #(
   parameter int W = 16
) (
   input  logic [W-1:0] x_i,
   output logic [W-1:0] y_o,
   output logic         zero_o
);

   always_comb begin
      y_o = (x_i == '0) ? '0 : x_i - W'(1);
      zero_o = (y_o == '0);
   end

endmodule

// File: rtl/monus_func_h.sv
// Truncated subtraction RES = IN0 monus IN1, one predecessor step per clock.
// Optional borrow output BRW is built when MONUS_BORROW_EN is defined.
//
//  state | meaning
//  IDLE  | waiting for ST; capture operands on ST
//  LOAD  | one settling cycle; skip iteration when either operand is 0
//  ITER  | decrement ACC and CNT until either reaches 0
//  DONE  | publish RES (and BRW), pulse RD; ST here restarts immediately
module monus_func_h
   import monus_func_h_pkg::*;
#(
   parameter int BW = BW_DEFAULT
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          ST,
   output logic          RD,
   output logic [BW-1:0] RES,
   input  logic [BW-1:0] IN0,
   input  logic [BW-1:0] IN1
`ifdef MONUS_BORROW_EN
   ,
   output logic          BRW
`endif
);

   state_e        state_q;
   logic [BW-1:0] acc_q;
   logic [BW-1:0] cnt_q;
   logic [BW-1:0] res_q;
   logic          rd_q;
   logic [BW-1:0] acc_dec;
   logic [BW-1:0] cnt_dec;
   logic          acc_zero;
   logic          cnt_zero;
`ifdef MONUS_BORROW_EN
   logic          brw_q;
`endif

   operation_p_step #(.W(BW)) u_acc_step (
      .x_i    (acc_q),
      .y_o    (acc_dec),
      .zero_o (acc_zero)
   );

   operation_p_step #(.W(BW)) u_cnt_step (
      .x_i    (cnt_q),
      .y_o    (cnt_dec),
      .zero_o (cnt_zero)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         rd_q    <= 1'b0;
`ifdef MONUS_BORROW_EN
         brw_q   <= 1'b0;
`endif
      end else begin
         rd_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ST) begin
                  acc_q   <= IN0;
                  cnt_q   <= IN1;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               state_q <= (cnt_q == '0 || acc_q == '0) ? DONE : ITER;
            end
            ITER: begin
               acc_q <= acc_dec;
               cnt_q <= cnt_dec;
               // Exit on whichever hits zero first; ACC reaching 0 is saturation.
               if (acc_zero || cnt_zero) state_q <= DONE;
            end
            DONE: begin
               rd_q  <= 1'b1;
               res_q <= acc_q;
`ifdef MONUS_BORROW_EN
               brw_q <= (cnt_q != '0);
`endif
               if (ST) begin
                  acc_q   <= IN0;
                  cnt_q   <= IN1;
                  state_q <= LOAD;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign RD  = rd_q;
   assign RES = res_q;
`ifdef MONUS_BORROW_EN
   assign BRW = brw_q;
`endif

endmodule

// File: tb/tb_monus_func_h.sv
// Self-checking bench for monus_func_h against an arithmetic reference model.
module tb_monus_func_h;

   localparam int BW = 16;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          ST  = 1'b0;
   logic          RD;
   logic [BW-1:0] RES;
   logic [BW-1:0] IN0 = '0;
   logic [BW-1:0] IN1 = '0;
`ifdef MONUS_BORROW_EN
   logic          BRW;
`endif

   int checks   = 0;
   int failures = 0;

   monus_func_h #(.BW(BW)) dut (
      .CLK (CLK),
      .RST (RST),
      .ST  (ST),
      .RD  (RD),
      .RES (RES),
      .IN0 (IN0),
      .IN1 (IN1)
`ifdef MONUS_BORROW_EN
      ,
      .BRW (BRW)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic int ref_res(int a, int b);
      return (a > b) ? a - b : 0;
   endfunction

   function automatic int ref_lat(int a, int b);
      if (a == 0 || b == 0) return 2;
      return 2 + ((a < b) ? a : b);
   endfunction

   function automatic int ref_brw(int a, int b);
      return (b > a) ? 1 : 0;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Waits for RD after a capture edge; returns edges counted from that edge.
   task automatic wait_rd(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (RD !== 1'b1 && n < 200);
   endtask

   task automatic run_op(input int a, input int b, input bit scramble, input string tag);
      int n;
      logic [BW-1:0] held;
      IN0 = BW'(a);
      IN1 = BW'(b);
      ST  = 1'b1;
      step();
      ST = 1'b0;
      if (scramble) begin
         IN0 = '0;
         IN1 = '0;
      end
      wait_rd(n);
      check({tag, "_lat"}, n, ref_lat(a, b));
      check({tag, "_res"}, int'(RES), ref_res(a, b));
`ifdef MONUS_BORROW_EN
      check({tag, "_brw"}, int'(BRW), ref_brw(a, b));
`endif
      held = RES;
      step();
      check({tag, "_rd_pulse"}, int'(RD), 0);
      check({tag, "_res_hold"}, int'(RES), int'(held));
   endtask

   initial begin
      int n;
      int pulses;
      int a;
      int b;

      // Reset state
      RST = 1'b0;
      step();
      step();
      check("rst_rd", int'(RD), 0);
      check("rst_res", int'(RES), 0);
`ifdef MONUS_BORROW_EN
      check("rst_brw", int'(BRW), 0);
`endif
      RST = 1'b1;
      step();

      // Directed cases
      run_op(10, 3, 1'b0, "d10_3");
      run_op(3, 10, 1'b0, "d3_10");
      run_op(0, 0, 1'b0, "d0_0");
      run_op(65535, 0, 1'b0, "dmax_0");
      run_op(0, 7, 1'b0, "d0_7");
      run_op(6, 6, 1'b0, "d6_6");
      run_op(9, 4, 1'b1, "dscramble");

      // ST held high: mid-iteration ST ignored, DONE-cycle ST restarts at once
      IN0 = 16'd5;
      IN1 = 16'd2;
      ST  = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
         wait_rd(n);
         check("b2b_period", n, ref_lat(5, 2));
         check("b2b_res", int'(RES), ref_res(5, 2));
      end
      ST = 1'b0;
      wait_rd(n);
      check("b2b_drain", n, ref_lat(5, 2));
      step();
      step();

      // Reset in the middle of a long iteration
      IN0 = 16'd100;
      IN1 = 16'd50;
      ST  = 1'b1;
      step();
      ST = 1'b0;
      for (int k = 0; k < 19; k++) step();
      RST = 1'b0;
      step();
      RST = 1'b1;
      check("abort_rd", int'(RD), 0);
      check("abort_res", int'(RES), 0);
      pulses = 0;
      for (int k = 0; k < 60; k++) begin
         step();
         if (RD === 1'b1) pulses++;
      end
      check("abort_no_rd", pulses, 0);
      run_op(100, 50, 1'b0, "after_abort");

      // Randomized operands
      for (int k = 0; k < 24; k++) begin
         if (k % 3 == 0) begin
            a = int'($urandom_range(65535, 0));
            b = int'($urandom_range(20, 0));
         end else begin
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
         end
         run_op(a, b, k[0], "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
